// File: rtl/timer_pkg.sv
// timer_pkg: shared state and mode encodings for the exposure timer.
// Holds no ports; imported by exposure_timer.
package timer_pkg;
   typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} timer_state_t;
   typedef enum logic {ONE_SHOT = 1'b0, AUTO_RELOAD = 1'b1} timer_mode_t;
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: divides clk into count steps of (pre+1) cycles.
// Ports: clk, reset (sync, active-high), clear (zero the phase counter),
// enable (advance this cycle), pre (cycles per step minus one),
// tick (combinational, high on the cycle a step completes).
module tick_prescaler #(
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [PRE_W-1:0] pre,
   output logic             tick
);
   logic [PRE_W-1:0] pcnt;
   assign tick = enable && (pcnt == pre);
   always_ff @(posedge clk) begin
      if (reset || clear) pcnt <= '0;
      else if (enable) pcnt <= tick ? '0 : pcnt + PRE_W'(1);
   end
endmodule

// File: rtl/exposure_timer.sv
// exposure_timer: prescaled exposure countdown with one-shot/auto-reload, pause and abort.
// Ports: clk, reset (sync, active-high); ex_set/ex_start/ex_pause/ex_abort controls;
// init/prescale/mode configuration latched on ex_set; registered outputs
// busy (ARMED or RUN), ex_done (DONE level), done_pulse (one cycle per expiry),
// count (remaining steps).
module exposure_timer
   import timer_pkg::*;
#(
   parameter int CNT_W = 5,
   parameter int PRE_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ex_set,
   input  logic             ex_start,
   input  logic             ex_pause,
   input  logic             ex_abort,
   input  logic [CNT_W-1:0] init,
   input  logic [PRE_W-1:0] prescale,
   input  logic             mode,
   output logic             busy,
   output logic             ex_done,
   output logic             done_pulse,
   output logic [CNT_W-1:0] count
);
   timer_state_t     state, state_n;
   timer_mode_t      mode_q, mode_n;
   logic [CNT_W-1:0] reload, reload_n, count_n;
   logic [PRE_W-1:0] pre_q, pre_n;
   logic             pulse_n, clear, enable, tick;

   tick_prescaler #(.PRE_W(PRE_W)) u_pre (
      .clk(clk), .reset(reset), .clear(clear), .enable(enable), .pre(pre_q), .tick(tick)
   );

   always_comb begin
      state_n  = state;
      count_n  = count;
      reload_n = reload;
      pre_n    = pre_q;
      mode_n   = mode_q;
      pulse_n  = 1'b0;
      clear    = 1'b0;
      enable   = 1'b0;
      if (ex_set) begin
         reload_n = init;
         pre_n    = prescale;
         mode_n   = timer_mode_t'(mode);
         count_n  = init;
         clear    = 1'b1;
         state_n  = (init == '0) ? DONE : ARMED;
         pulse_n  = (init == '0);
      end else if (ex_abort && state != IDLE) begin
         state_n = IDLE;
         count_n = '0;
         clear   = 1'b1;
      end else begin
         case (state)
            ARMED: state_n = ex_start ? RUN : ARMED;
            DONE: if (ex_start) begin
               state_n = RUN;
               count_n = reload;
               clear   = 1'b1;
            end
            RUN: begin
               enable = !ex_pause;
               if (tick && count > CNT_W'(1)) count_n = count - CNT_W'(1);
               else if (tick && count == CNT_W'(1)) begin
                  pulse_n = 1'b1;
                  count_n = (mode_q == AUTO_RELOAD) ? reload : '0;
                  state_n = (mode_q == AUTO_RELOAD) ? RUN : DONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         reload     <= '0;
         pre_q      <= '0;
         mode_q     <= ONE_SHOT;
         busy       <= 1'b0;
         ex_done    <= 1'b0;
         done_pulse <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload     <= reload_n;
         pre_q      <= pre_n;
         mode_q     <= mode_n;
         busy       <= (state_n == ARMED) || (state_n == RUN);
         ex_done    <= (state_n == DONE);
         done_pulse <= pulse_n;
      end
   end
endmodule

// File: tb/tb_exposure_timer.sv
// tb_exposure_timer: directed self-checking bench for exposure_timer (default parameters).
module tb_exposure_timer;
   logic       clk = 1'b0;
   logic       reset, ex_set, ex_start, ex_pause, ex_abort, mode;
   logic [4:0] init;
   logic [3:0] prescale;
   logic       busy, ex_done, done_pulse;
   logic [4:0] count;
   int         checks = 0;
   int         errors = 0;

   exposure_timer dut (
      .clk(clk), .reset(reset), .ex_set(ex_set), .ex_start(ex_start),
      .ex_pause(ex_pause), .ex_abort(ex_abort), .init(init), .prescale(prescale),
      .mode(mode), .busy(busy), .ex_done(ex_done), .done_pulse(done_pulse), .count(count)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int c, input int b, input int d, input int p);
      chk({tag, ".count"}, int'(count), c);
      chk({tag, ".busy"}, int'(busy), b);
      chk({tag, ".ex_done"}, int'(ex_done), d);
      chk({tag, ".done_pulse"}, int'(done_pulse), p);
   endtask

   task automatic arm(input int i, input int p, input int m);
      init = 5'(i); prescale = 4'(p); mode = m[0];
      ex_set = 1'b1; step(); ex_set = 1'b0;
   endtask

   task automatic start();
      ex_start = 1'b1; step(); ex_start = 1'b0;
   endtask

   initial begin
      reset = 1'b1; ex_set = 0; ex_start = 0; ex_pause = 0; ex_abort = 0;
      mode = 0; init = 0; prescale = 0;
      step(); step();
      chk_all("reset", 0, 0, 0, 0);
      reset = 1'b0;
      step();
      chk_all("idle", 0, 0, 0, 0);

      arm(10, 0, 0);
      chk_all("t1_armed", 10, 1, 0, 0);
      start();
      chk_all("t1_e0", 10, 1, 0, 0);
      for (int k = 1; k <= 9; k++) begin
         step();
         chk_all("t1_run", 10 - k, 1, 0, 0);
      end
      step();
      chk_all("t1_expire", 0, 0, 1, 1);
      step();
      chk_all("t1_after", 0, 0, 1, 0);

      arm(3, 2, 0);
      start();
      for (int k = 1; k <= 9; k++) begin
         step();
         if (k < 9) chk_all("t2_run", 3 - k / 3, 1, 0, 0);
         else chk_all("t2_expire", 0, 0, 1, 1);
      end

      arm(4, 0, 1);
      start();
      for (int k = 1; k <= 13; k++) begin
         step();
         chk_all("t3_reload", (k % 4 == 0) ? 4 : 4 - (k % 4), 1, 0, (k % 4 == 0) ? 1 : 0);
      end
      ex_abort = 1'b1; step(); ex_abort = 1'b0;
      chk_all("t3_abort", 0, 0, 0, 0);

      arm(5, 0, 0);
      start();
      step();
      chk_all("t4_k1", 4, 1, 0, 0);
      ex_pause = 1'b1;
      for (int k = 2; k <= 4; k++) begin
         step();
         chk_all("t4_pause", 4, 1, 0, 0);
      end
      ex_pause = 1'b0;
      for (int k = 5; k <= 8; k++) begin
         step();
         if (k < 8) chk_all("t4_run", 8 - k, 1, 0, 0);
         else chk_all("t4_expire", 0, 0, 1, 1);
      end

      arm(10, 0, 0);
      start();
      step(); step();
      chk_all("t5_pre_abort", 8, 1, 0, 0);
      ex_abort = 1'b1; step(); ex_abort = 1'b0;
      chk_all("t5_abort", 0, 0, 0, 0);
      start();
      chk_all("t5_start_ignored", 0, 0, 0, 0);
      step();
      chk_all("t5_still_idle", 0, 0, 0, 0);

      arm(0, 0, 0);
      chk_all("t6_zero", 0, 0, 1, 1);
      step();
      chk_all("t6_zero_after", 0, 0, 1, 0);

      init = 5'd5; prescale = 0; mode = 0;
      ex_set = 1'b1; ex_start = 1'b1; step(); ex_set = 1'b0; ex_start = 1'b0;
      chk_all("t7_set_start", 5, 1, 0, 0);
      step();
      chk_all("t7_armed_hold", 5, 1, 0, 0);
      start();
      step();
      chk_all("t8_k1", 4, 1, 0, 0);
      ex_start = 1'b1; step(); ex_start = 1'b0;
      chk_all("t8_start_in_run", 3, 1, 0, 0);

      reset = 1'b1; step(); reset = 1'b0;
      chk_all("t9_reset_mid_run", 0, 0, 0, 0);

      arm(2, 0, 0);
      start();
      step(); step();
      chk_all("t10_done", 0, 0, 1, 1);
      start();
      chk_all("t10_restart", 2, 1, 0, 0);
      step();
      chk_all("t10_run", 1, 1, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/exposure_timer.md
Name: exposure_timer

Overview:
- Parametrised exposure timer. Next generation of the 5-bit exposure counter used by the camera control FSM.
- Adds configurable count width, a clock prescaler, one-shot and auto-reload modes, pause and abort.
- Sits between the control FSM (which drives set/start/abort) and the pixel-array exposure/readout sequencing.
- Produces a done level, a single-cycle done pulse, and the live remaining count.

Parameters:
CNT_W, 5, width of exposure count, init and count
PRE_W, 4, width of prescale value; one count step = prescale+1 clk cycles

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
ex_set  input  1  load init/prescale/mode, arm timer
ex_start  input  1  begin counting (from ARMED or DONE)
ex_pause  input  1  level; freezes counting while high in RUN
ex_abort  input  1  cancel active exposure
init  input  CNT_W  exposure length in count steps
prescale  input  PRE_W  cycles per step minus one
mode  input  1  0 = one-shot, 1 = auto-reload
busy  output  1  high in ARMED and RUN
ex_done  output  1  level, high only in state DONE
done_pulse  output  1  one-cycle pulse per expiry
count  output  CNT_W  remaining steps

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values: state IDLE, count 0, prescaler counter 0, busy 0, ex_done 0, done_pulse 0. All outputs are registered.
- States: IDLE, ARMED, RUN, DONE. Input priority per edge: reset > ex_set > ex_abort > ex_start > ex_pause/tick.
- ex_set, any state:
  - Latch reload=init, pre=prescale, mode; set count=init, pcnt=0.
  - Go to ARMED.
  - If init==0: go straight to DONE, with done_pulse=1 for that one cycle.
- ARMED: ex_start goes to RUN; no tick occurs on that edge.
- IDLE: ex_start and ex_pause are ignored.
- RUN, each edge with ex_pause=0:
  - If pcnt==pre: pcnt=0 and a tick occurs; otherwise pcnt+1.
  - On a tick with count>1: count-1.
  - On a tick with count==1 and mode=0: count=0, go to DONE, done_pulse=1.
  - On a tick with count==1 and mode=1: count=reload, done_pulse=1, stay in RUN. ex_done stays 0.
- RUN with ex_pause=1: count and pcnt hold; busy stays 1.
- Latency: start sampled at edge E0 gives first expiry at edge E0 + init*(prescale+1), plus the number of paused edges.
- DONE: ex_done=1, count=0.
  - ex_start reloads count=reload, pcnt=0, goes to RUN and clears ex_done.
  - ex_set is handled as above.
- ex_abort in ARMED, RUN or DONE: go to IDLE, count=0, pcnt=0, no done_pulse.
- ex_set and ex_start on the same edge: ex_set wins, leaving the timer ARMED. A new start is required.
- ex_start while in RUN is ignored; it does not restart the count.
- Reset mid-run returns to reset values on the next edge, with no pulse.
- Count arithmetic is unsigned, CNT_W bits, and never wraps below 0. Max exposure = (2^CNT_W-1)*2^PRE_W cycles.

Decomposition:
- Package timer_pkg holds:
  - timer_state_t enum: IDLE, ARMED, RUN, DONE.
  - timer_mode_t enum: ONE_SHOT=0, AUTO_RELOAD=1.
- One sub-module, tick_prescaler:
  - Parameter PRE_W; ports clk, reset, clear, enable, pre.
  - Produces a one-cycle tick when pcnt==pre and enable=1.
- The main FSM and count register live in exposure_timer.

Test Plan:
- Default params, init=10, prescale=0, mode=0: set, then start at E0. Count steps 10→0, one per cycle; ex_done and done_pulse rise at E0+10; done_pulse lasts 1 cycle; busy falls at the same edge.
- init=3, prescale=2: expiry at E0+9; count changes only at E0+3, E0+6, E0+9.
- init=4, prescale=0, mode=1: done_pulse at E0+4, +8, +12; ex_done stays 0; busy stays 1; count sequence 4,3,2,1,4,...
- init=5, prescale=0, ex_pause high for 3 edges at E0+2..E0+4: count holds at 4; expiry at E0+8.
- Abort at E0+3 with init=10: state IDLE, count=0, no done_pulse. A later ex_start is ignored until the next ex_set.
- init=0 set: DONE next edge with one done_pulse. Separately, reset asserted mid-RUN: all outputs return to 0 on the next edge.
